// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the data-memory arbiter.
package mem_arb_pkg;
  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 32;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic       {OWN_CPU, OWN_DBG}        arb_owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU port, debug port and memory port of the arbiter.
// slave = arbiter view, master = core/debugger/memory view.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();
  logic          cpu_req, cpu_we, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall, dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks the owner of the next transaction.
// MEM_ARB_RR_EN defined: round-robin on ties via a last-owner register.
// Undefined: fixed priority, CPU wins every tie.
module mem_arb_grant import mem_arb_pkg::*; (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cpu_req,
  input  logic       i_dbg_req,
  input  logic       i_take,
  output arb_owner_t o_grant
);
`ifdef MEM_ARB_RR_EN
  arb_owner_t r_last;

  // last-owner register; resets to DBG so the CPU wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_last <= OWN_DBG;
    else if (i_take) r_last <= o_grant;
  end

  // on a tie the port not granted last wins
  always_comb begin
    o_grant = OWN_CPU;
    if (i_cpu_req && i_dbg_req) o_grant = (r_last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    else if (i_dbg_req)         o_grant = OWN_DBG;
  end
`else
  logic w_unused;
  assign w_unused = ^{i_clk, i_rst_n, i_take};

  // fixed priority: debug only when the CPU is not asking
  always_comb begin
    o_grant = OWN_CPU;
    if (!i_cpu_req && i_dbg_req) o_grant = OWN_DBG;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency synchronous memory between the MEM
// stage and a debug/loader port, one transaction at a time.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking in mem_arb_grant.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  mem_arbiter_if.slave io_bus
);
  // WAIT runs MEM_LAT-1 cycles: counter loads MEM_LAT-2 and exits at zero
  localparam int            CW       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MEM_LAT > 2) ? CW'(MEM_LAT - 2) : '0;

  arb_state_t    r_state, w_next;
  arb_owner_t    r_owner, w_grant;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_cpu_rdata, r_dbg_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_take, w_cap, w_issue, w_done_cpu;

  mem_arb_grant u_grant (
    .i_clk     (i_clk),
    .i_rst_n   (i_reset),
    .i_cpu_req (io_bus.cpu_req),
    .i_dbg_req (io_bus.dbg_req),
    .i_take    (w_take),
    .o_grant   (w_grant)
  );

  // state register; async reset aborts any transaction in flight
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next state, grant strobe and read-data capture strobe
  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE:  if (io_bus.cpu_req || io_bus.dbg_req) begin
               w_take = 1'b1;
               w_next = ISSUE;
             end
      ISSUE: if (r_we)              w_next = DONE;
             else if (MEM_LAT == 1) begin
               w_next = DONE;
               w_cap  = 1'b1;
             end
             else                   w_next = WAIT;
      WAIT:  if (r_cnt == '0) begin
               w_next = DONE;
               w_cap  = 1'b1;
             end
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // request latch, latency counter and per-owner read-data registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_owner     <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_grant;
        r_we    <= (w_grant == OWN_CPU) ? io_bus.cpu_we    : io_bus.dbg_we;
        r_addr  <= (w_grant == OWN_CPU) ? io_bus.cpu_addr  : io_bus.dbg_addr;
        r_wdata <= (w_grant == OWN_CPU) ? io_bus.cpu_wdata : io_bus.dbg_wdata;
      end
      if (r_state == ISSUE)                    r_cnt <= CNT_LOAD;
      else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      if (w_cap) begin
        if (r_owner == OWN_CPU) r_cpu_rdata <= io_bus.mem_rdata;
        else                    r_dbg_rdata <= io_bus.mem_rdata;
      end
    end
  end

  assign w_issue    = (r_state == ISSUE);
  assign w_done_cpu = (r_state == DONE) && (r_owner == OWN_CPU);

  assign io_bus.mem_en    = w_issue;
  assign io_bus.mem_we    = w_issue & r_we;
  assign io_bus.mem_addr  = w_issue ? r_addr  : '0;
  assign io_bus.mem_wdata = w_issue ? r_wdata : '0;

  // stall is combinational so the pipeline advances on the DONE edge
  assign io_bus.cpu_stall = io_bus.cpu_req & ~w_done_cpu;
  assign io_bus.dbg_ack   = (r_state == DONE) && (r_owner == OWN_DBG);
  assign io_bus.cpu_rdata = r_cpu_rdata;
  assign io_bus.dbg_rdata = r_dbg_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized CPU/debug traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam int TIE2_AT = 3;
`else
  localparam int TIE2_AT = 7;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(32), .AW(32)) bus ();

  mem_arbiter #(.DW(32), .AW(32), .MEM_LAT(LAT)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (bus)
  );

  // behavioural memory: one register stage gives capture LAT-1 edges after issue
  logic [31:0] dev_mem [64];
  logic [31:0] rd_q;
  assign bus.mem_rdata = rd_q;

  function automatic logic [31:0] init_val(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) dev_mem[i] <= init_val(i);
    rd_q <= '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) dev_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        else            rd_q <= dev_mem[bus.mem_addr[7:2]];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: each grant opens a window [start, done] computed from latency
  bit          m_busy = 1'b0;
  int          m_start, m_done;
  arb_owner_t  m_own, m_last = OWN_DBG;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rval;
  logic [31:0] exp_cpu_rd = '0, exp_dbg_rd = '0;
  logic [31:0] ref_mem [64];
  bit          o_stall, o_ack;
  logic [31:0] iss_addr, iss_data;
  bit          iss_we;

  initial for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

  task automatic eval_cycle();
    bit done_now, issue_now;
    #1;
    if (!rst_n) begin
      m_busy = 1'b0; m_last = OWN_DBG; exp_cpu_rd = '0; exp_dbg_rd = '0;
      chk("rst_mem_en",  32'(bus.mem_en), 0);
      chk("rst_mem_we",  32'(bus.mem_we), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_ack",     32'(bus.dbg_ack), 0);
      chk("rst_stall",   32'(bus.cpu_stall), 32'(bus.cpu_req));
      chk("rst_cpu_rd",  bus.cpu_rdata, 0);
      chk("rst_dbg_rd",  bus.dbg_rdata, 0);
    end else begin
      if (m_busy && cyc > m_done) m_busy = 1'b0;
      if (!m_busy && (bus.cpu_req || bus.dbg_req)) begin
        if (bus.cpu_req && bus.dbg_req) begin
`ifdef MEM_ARB_RR_EN
          m_own = (m_last == OWN_CPU) ? OWN_DBG : OWN_CPU;
`else
          m_own = OWN_CPU;
`endif
        end else m_own = bus.cpu_req ? OWN_CPU : OWN_DBG;
        m_last = m_own;
        if (m_own == OWN_CPU) begin
          m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
        end else begin
          m_we = bus.dbg_we; m_addr = bus.dbg_addr; m_wdata = bus.dbg_wdata;
        end
        m_start = cyc;
        m_done  = cyc + (m_we ? 2 : LAT + 1);
        m_busy  = 1'b1;
        if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
        else      m_rval = ref_mem[m_addr[7:2]];
      end
      done_now  = m_busy && (cyc == m_done);
      issue_now = m_busy && (cyc == m_start + 1);
      if (done_now && !m_we) begin
        if (m_own == OWN_CPU) exp_cpu_rd = m_rval;
        else                  exp_dbg_rd = m_rval;
      end
      chk("mem_en",    32'(bus.mem_en), 32'(issue_now));
      chk("mem_we",    32'(bus.mem_we), 32'(issue_now && m_we));
      chk("mem_addr",  bus.mem_addr,  issue_now ? m_addr  : 32'h0);
      chk("mem_wdata", bus.mem_wdata, issue_now ? m_wdata : 32'h0);
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !(done_now && m_own == OWN_CPU)));
      chk("dbg_ack",   32'(bus.dbg_ack),   32'(done_now && m_own == OWN_DBG));
      chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
      chk("dbg_rdata", bus.dbg_rdata, exp_dbg_rd);
    end
    if (bus.mem_en) begin
      iss_addr = bus.mem_addr; iss_data = bus.mem_wdata; iss_we = bus.mem_we;
    end
    o_stall = bus.cpu_stall;
    o_ack   = bus.dbg_ack;
    cyc++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(bit req, bit we, logic [31:0] a, logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dbg(bit req, bit we, logic [31:0] a, logic [31:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  // CPU access held while stalled; returns stall cycles and rdata in the completion cycle
  task automatic cpu_xfer(bit we, logic [31:0] a, logic [31:0] d,
                          output int nstall, output logic [31:0] rd);
    nstall = 0;
    nxt(); set_cpu(1'b1, we, a, d); eval_cycle();
    for (int k = 0; k < 20 && o_stall; k++) begin
      nstall++;
      nxt(); eval_cycle();
    end
    if (o_stall) chk("cpu_timeout", 1, 0);
    rd = bus.cpu_rdata;
    nxt(); set_cpu(1'b0, 1'b0, '0, '0); eval_cycle();
  endtask

  // debug access held until ack; counts ack-high cycles including the one after
  task automatic dbg_xfer(bit we, logic [31:0] a, logic [31:0] d,
                          output int nack, output logic [31:0] rd);
    nack = 0;
    nxt(); set_dbg(1'b1, we, a, d); eval_cycle();
    for (int k = 0; k < 20 && !o_ack; k++) begin
      nxt(); eval_cycle();
    end
    if (o_ack) nack++;
    else chk("dbg_timeout", 1, 0);
    rd = bus.dbg_rdata;
    nxt(); set_dbg(1'b0, 1'b0, '0, '0); eval_cycle();
    if (o_ack) nack++;
  endtask

  // both ports read in the same idle cycle; returns the cycle of dbg_ack
  task automatic tie(output int ack_at);
    bit cpu_on, dbg_on;
    int t;
    cpu_on = 1'b1; dbg_on = 1'b1; ack_at = -1; t = 0;
    nxt(); set_cpu(1'b1, 1'b0, 32'h40, '0); set_dbg(1'b1, 1'b0, 32'h80, '0); eval_cycle();
    while ((cpu_on || dbg_on) && t < 30) begin
      if (dbg_on && o_ack)  begin ack_at = t; dbg_on = 1'b0; end
      if (cpu_on && !o_stall) cpu_on = 1'b0;
      t++;
      nxt(); bus.cpu_req = cpu_on; bus.dbg_req = dbg_on; eval_cycle();
    end
    if (cpu_on || dbg_on) chk("tie_timeout", 1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, n2, acks, stalls, at;
    logic [31:0] rd;
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    #1 rst_n = 1'b0;
    bus.cpu_req = 1'b1;
    eval_cycle();
    nxt(); bus.cpu_req = 1'b0; eval_cycle();
    nxt(); eval_cycle();
    nxt(); rst_n = 1'b1; eval_cycle();

    cpu_xfer(1'b1, 32'd84, 32'h0310, n, rd);
    chk("st_stalls", 32'(n), 2);
    chk("st_addr", iss_addr, 32'd84);
    chk("st_data", iss_data, 32'h0310);
    chk("st_we", 32'(iss_we), 1);

    dbg_xfer(1'b1, 32'd80, 32'd7, acks, rd);
    cpu_xfer(1'b0, 32'd80, '0, n, rd);
    chk("ld_stalls", 32'(n), 3);
    chk("ld_rdata", rd, 32'd7);

    dbg_xfer(1'b1, 32'h40, 32'hDEAD, acks, rd);
    chk("dw_acks", 32'(acks), 1);
    dbg_xfer(1'b0, 32'h40, '0, acks, rd);
    chk("dr_acks", 32'(acks), 1);
    chk("dr_rdata", rd, 32'hDEAD);

    tie(at);
    chk("tie1_ack_at", 32'(at), 7);
    cpu_xfer(1'b1, 32'h100, 32'h55, n, rd);
    tie(at);
    chk("tie2_ack_at", 32'(at), 32'(TIE2_AT));

    // reset during WAIT of a CPU read
    nxt(); set_cpu(1'b1, 1'b0, 32'd80, '0); eval_cycle();
    nxt(); eval_cycle();
    nxt(); rst_n = 1'b0; bus.cpu_req = 1'b0; eval_cycle();
    chk("rstw_mem_en", 32'(bus.mem_en), 0);
    chk("rstw_cpu_rd", bus.cpu_rdata, 0);
    nxt(); eval_cycle();
    nxt(); rst_n = 1'b1; eval_cycle();
    cpu_xfer(1'b0, 32'h40, '0, n, rd);
    chk("rstw_ld_stalls", 32'(n), 3);
    chk("rstw_ld_rdata", rd, 32'hDEAD);

    // CPU drops its request during WAIT
    nxt(); set_cpu(1'b1, 1'b0, 32'd84, '0); eval_cycle();
    nxt(); eval_cycle();
    nxt(); bus.cpu_req = 1'b0; eval_cycle();
    acks = 0; stalls = 0;
    for (int k = 0; k < 4; k++) begin
      nxt(); eval_cycle();
      acks += int'(o_ack); stalls += int'(o_stall);
    end
    chk("drop_acks", 32'(acks), 0);
    chk("drop_stalls", 32'(stalls), 0);
    chk("drop_rdata", bus.cpu_rdata, 32'h0310);

    // randomized traffic from both ports
    for (int k = 0; k < 1500; k++) begin
      nxt();
      if (bus.cpu_req && o_stall) begin
        if ($urandom_range(0, 99) < 3) bus.cpu_req = 1'b0;
      end else begin
        set_cpu($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)), $urandom(), $urandom());
      end
      if (!(bus.dbg_req && !o_ack))
        set_dbg($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)), $urandom(), $urandom());
      eval_cycle();
    end
    n2 = 0;
    while ((bus.cpu_req && o_stall) || (bus.dbg_req && !o_ack)) begin
      nxt();
      if (!(bus.cpu_req && o_stall)) bus.cpu_req = 1'b0;
      if (!(bus.dbg_req && !o_ack)) bus.dbg_req = 1'b0;
      eval_cycle();
      n2++;
      if (n2 > 40) begin
        chk("drain_timeout", 1, 0);
        break;
      end
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    set_dbg(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      nxt(); eval_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port data memory between the pipelined MIPS core's MEM stage and a debug/loader port. Accepts one transaction at a time, sequences it through a fixed-latency synchronous memory, stalls the pipeline until a CPU access completes, and acknowledges debug accesses. It sits between the core's data-memory interface and the data memory inside `top`. Its memory-side outputs are the `memwrite`/`dataadr`/`writedata` signals that `top` exports to the bench.

## Interface
- `DW`, 32, data width
- `AW`, 32, byte address width
- `MEM_LAT`, 2, cycles from the memory issue edge to valid `mem_rdata`; must be ≥1
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  MEM-stage access request; held while `cpu_stall`=1
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  AW  byte address
- `cpu_wdata`  in  DW  store data
- `cpu_rdata`  out  DW  load data, registered
- `cpu_stall`  out  1  freeze the pipeline
- `dbg_req`  in  1  debug request; held until `dbg_ack`
- `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/AW/DW  as for the CPU port
- `dbg_rdata`  out  DW  registered
- `dbg_ack`  out  1  one-cycle completion pulse
- `mem_en`, `mem_we`  out  1  memory strobe and write enable
- `mem_addr`, `mem_wdata`  out  AW/DW  memory address and write data
- `mem_rdata`  in  DW  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any request is present, grant one (see Configuration), latch owner/we/addr/wdata, and go to ISSUE.
- ISSUE: `mem_en`=1, `mem_we`=latched we, address and data from the latch.
  - Write → DONE.
  - Read with `MEM_LAT`=1 → DONE.
  - Read otherwise → WAIT, with the counter loaded to `MEM_LAT`-2.
- WAIT: `mem_en`=0. Decrement the counter; at 0 go to DONE. On that final edge, capture `mem_rdata` into the owner's rdata register.
- DONE: completion cycle, then → IDLE. No back-to-back issue from DONE.
- Outside ISSUE, `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- `cpu_stall` = `cpu_req` & !(state==DONE & owner==CPU). It is combinational, so the pipeline advances on the DONE edge.
- `dbg_ack` = (state==DONE & owner==DBG).
- rdata registers hold their value until the next read by the same owner. Writes leave them unchanged.
- A request dropped mid-transaction still completes on the memory. The response is delivered but ignored.
- Addresses pass through unmodified; the memory ignores `addr[1:0]`.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, owner CPU, `cpu_rdata`/`dbg_rdata`=0, `mem_*`=0, `dbg_ack`=0. `cpu_stall` follows `cpu_req` combinationally.
- Reset asserted mid-transaction aborts immediately. `mem_en` drops in the same cycle and no ack is issued.
- Uncontended read: request seen in IDLE at cycle 0; ISSUE at cycle 1; DONE at cycle `MEM_LAT`+1. `cpu_stall` is high for cycles 0..`MEM_LAT`.
- Uncontended write: ISSUE at cycle 1, DONE at cycle 2, 2 stall cycles.
- A request arriving while busy waits. The CPU sees stall; the debug port sees no ack.
- Simultaneous requests in IDLE are resolved by the grant policy. The loser is granted on the next IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. A one-bit last-owner register (reset: DBG, so the CPU wins the first tie) is updated at each grant. On a tie, the port not granted last wins.
- Undefined: fixed priority, CPU always wins ties. The debug port can starve while the CPU issues back-to-back accesses; this is accepted.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, DONE}
  - `arb_owner_t` enum {OWN_CPU, OWN_DBG}
  - default width constants
- Sub-module `mem_arb_grant`: takes both requests plus the last owner and outputs the granted owner. It holds the `MEM_ARB_RR_EN` logic and the last-owner register.
- The FSM, latches and latency counter live in `mem_arbiter`.

## Test plan
All cases use `MEM_LAT`=2.
- CPU store: addr 84, data 0x0310 → one ISSUE cycle with `mem_we`=1, `mem_addr`=84, `mem_wdata`=0x0310. `cpu_stall` high for exactly 2 cycles.
- CPU load: addr 80, memory returns 7 → `cpu_rdata`=7 in the DONE cycle (cycle 3). `cpu_stall` high in cycles 0–2 and low in cycle 3.
- Both ports request a read in the same IDLE cycle.
  - Fixed priority: CPU served first, then debug; `dbg_ack` at cycle 7.
  - `MEM_ARB_RR_EN`: after a debug-only access, the next tie goes to CPU; the tie after that goes to DBG.
- Debug write followed by debug read of the same address 0x40, data 0xDEAD → `dbg_ack` pulses twice, one cycle each; `dbg_rdata`=0xDEAD.
- Reset asserted in WAIT of a CPU read → `mem_en`=0 and `cpu_rdata`=0 immediately. After release, a new read completes normally.
- CPU drops `cpu_req` during WAIT → the memory still completes the transaction, then the arbiter returns to IDLE with no stall and no spurious `dbg_ack`.
